// File: rtl/pc_sequencer.sv
// Program-counter sequencing FSM: fetch handshake, next-PC selection and a
// small circular return-address stack. The PC register itself lives outside.
module pc_sequencer #(
  parameter int              PC_W      = 6,
  parameter int              RAS_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_VEC = '0,
  localparam int             CNT_W     = $clog2(RAS_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [PC_W-1:0]  pc_cur,
  output logic [PC_W-1:0]  pc_next,
  output logic             pc_we,
  output logic             fetch_req,
  output logic [PC_W-1:0]  fetch_addr,
  input  logic             mem_ack,
  input  logic             stall,
  input  logic             halt,
  input  logic             jump,
  input  logic             call,
  input  logic             ret,
  input  logic             branch_taken,
  input  logic [PC_W-1:0]  target,
  output logic             busy,
  output logic             halted,
  output logic [CNT_W-1:0] ras_count,
  output logic             ras_ovf,
  output logic             ras_err
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] FETCH  = 2'd1;
  localparam logic [1:0] DECODE = 2'd2;
  localparam logic [1:0] HALT   = 2'd3;

  localparam int              PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(RAS_DEPTH);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(RAS_DEPTH - 1);
  localparam logic [PC_W-1:0]  ONE  = PC_W'(1);

  logic [1:0] state, nstate;

  // sp points at the next free slot; the stack wraps so an overflowing call
  // silently overwrites the oldest entry.
  logic [RAS_DEPTH-1:0][PC_W-1:0] ras_q;
  logic [PTR_W-1:0]               sp, sp_inc, sp_dec;
  logic [PC_W-1:0]                ras_top, pc_inc;
  logic                           do_push, do_pop, set_err, ras_clr;

  assign sp_inc  = (sp == LAST) ? '0 : sp + 1'b1;
  assign sp_dec  = (sp == '0) ? LAST : sp - 1'b1;
  assign ras_top = ras_q[sp_dec];
  assign pc_inc  = pc_cur + ONE;

  assign fetch_addr = pc_cur;
  assign busy       = (state == FETCH) || (state == DECODE);
  assign halted     = (state == HALT);

  always_comb begin
    nstate    = state;
    pc_next   = pc_cur;
    pc_we     = 1'b0;
    fetch_req = 1'b0;
    do_push   = 1'b0;
    do_pop    = 1'b0;
    set_err   = 1'b0;
    ras_clr   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          pc_next = RESET_VEC;
          pc_we   = 1'b1;
          nstate  = FETCH;
        end
      end
      FETCH: begin
        fetch_req = 1'b1;
        if (mem_ack) nstate = DECODE;
      end
      DECODE: begin
        if (!stall) begin
          if (halt) begin
            nstate = HALT;
          end else if (ret) begin
            if (ras_count != '0) begin
              pc_next = ras_top;
              pc_we   = 1'b1;
              do_pop  = 1'b1;
              nstate  = FETCH;
            end else begin
              set_err = 1'b1;
              nstate  = HALT;
            end
          end else if (call) begin
            pc_next = target;
            pc_we   = 1'b1;
            do_push = 1'b1;
            nstate  = FETCH;
          end else if (jump || branch_taken) begin
            pc_next = target;
            pc_we   = 1'b1;
            nstate  = FETCH;
          end else begin
            pc_next = pc_inc;
            pc_we   = 1'b1;
            nstate  = FETCH;
          end
        end
      end
      default: begin
        if (start) begin
          pc_next = RESET_VEC;
          pc_we   = 1'b1;
          ras_clr = 1'b1;
          nstate  = FETCH;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      ras_q     <= '0;
      sp        <= '0;
      ras_count <= '0;
      ras_ovf   <= 1'b0;
      ras_err   <= 1'b0;
    end else begin
      state <= nstate;
      if (ras_clr) begin
        sp        <= '0;
        ras_count <= '0;
        ras_ovf   <= 1'b0;
        ras_err   <= 1'b0;
      end else if (do_push) begin
        ras_q[sp] <= pc_inc;
        sp        <= sp_inc;
        if (ras_count == FULL) ras_ovf <= 1'b1;
        else                   ras_count <= ras_count + 1'b1;
      end else if (do_pop) begin
        sp        <= sp_dec;
        ras_count <= ras_count - 1'b1;
      end
      if (set_err) ras_err <= 1'b1;
    end
  end

endmodule
